aes128_round_ctrl: RTL and testbench

AES128_ROUND_CTRL -- requirements
Module: aes128_round_ctrl

---
 rtl/aes128_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_ctrl.sv
// AES-128 round sequencer: LOAD, ten ROUND cycles with xtime-generated RCON, then HOLD until acknowledged.
// Optional abort path is compiled in only when AES_ABORT_EN is defined.
module aes128_round_ctrl (
    input  logic       clk_i,
    input  logic       rstb_i,
    input  logic       start_i,
    input  logic       out_ack_i,
    input  logic       abort_i,
    output logic       load_o,
    output logic       round_en_o,
    output logic       final_o,
    output logic [3:0] round_o,
    output logic [7:0] rcon_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [7:0] RCON_FIRST = 8'h01;

    // GF(2^8) doubling modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rc_q, rc_d;

    logic       load_q, load_d;
    logic       round_en_q, round_en_d;
    logic       final_q, final_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

`ifndef AES_ABORT_EN
    logic unused_abort;
    assign unused_abort = abort_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd0;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                cnt_d   = 4'd1;
                rc_d    = RCON_FIRST;
            end
            S_ROUND: begin
                if (cnt_q >= LAST_ROUND) begin
                    state_d = S_HOLD;
                    cnt_d   = LAST_ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    rc_d  = xtime(rc_q);
                end
            end
            S_HOLD: begin
                // Acknowledge plus a pending request chains straight into the next block.
                if (out_ack_i) begin
                    state_d = start_i ? S_LOAD : S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
`ifdef AES_ABORT_EN
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            rc_d    = 8'h00;
        end
`endif
    end

    // Outputs are decoded from the next state and registered, so no input reaches a port combinationally.
    always_comb begin
        load_d     = (state_d == S_LOAD);
        round_en_d = (state_d == S_ROUND);
        final_d    = round_en_d && (cnt_d == LAST_ROUND);
        busy_d     = load_d || round_en_d;
        done_d     = (state_d == S_HOLD);
        round_d    = (round_en_d || done_d) ? cnt_d : 4'd0;
        rcon_d     = round_en_d ? rc_d : 8'h00;
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rc_q       <= 8'h00;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            final_q    <= 1'b0;
            round_q    <= 4'd0;
            rcon_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rc_q       <= rc_d;
            load_q     <= load_d;
            round_en_q <= round_en_d;
            final_q    <= final_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign load_o     = load_q;
    assign round_en_o = round_en_q;
    assign final_o    = final_q;
    assign round_o    = round_q;
    assign rcon_o     = rcon_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl; output vector is {load, round_en, final, busy, done, round, rcon}.
module tb_aes128_round_ctrl;

    logic       clk = 1'b0;
    logic       rstb, start, out_ack, abort;
    logic       load, round_en, fin, busy, done;
    logic [3:0] round;
    logic [7:0] rcon;

    int checks = 0;
    int errors = 0;

    aes128_round_ctrl dut (
        .clk_i      (clk),
        .rstb_i     (rstb),
        .start_i    (start),
        .out_ack_i  (out_ack),
        .abort_i    (abort),
        .load_o     (load),
        .round_en_o (round_en),
        .final_o    (fin),
        .round_o    (round),
        .rcon_o     (rcon),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {load, round_en, fin, busy, done, round, rcon};

    function automatic logic [16:0] pack(input logic l, input logic re, input logic f,
                                         input logic b, input logic d,
                                         input logic [3:0] r, input logic [7:0] rc);
        return {l, re, f, b, d, r, rc};
    endfunction

    function automatic logic [7:0] exp_rcon(input int r);
        case (r)
            1:  return 8'h01;
            2:  return 8'h02;
            3:  return 8'h04;
            4:  return 8'h08;
            5:  return 8'h10;
            6:  return 8'h20;
            7:  return 8'h40;
            8:  return 8'h80;
            9:  return 8'h1b;
            10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    localparam logic [16:0] IDLE_V = 17'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] e;
        rstb = 1'b0; start = 1'b0; out_ack = 1'b0; abort = 1'b0;
        #2;
        e = IDLE_V;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_async: got %h want %h", obs, e); end
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_held: got %h want %h", obs, e); end
        start = 1'b0;
        #2 rstb = 1'b1;
        tick();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_release_idle: got %h want %h", obs, e); end
    endtask

    task automatic test_sequence();
        logic [16:0] e;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = pack(1, 0, 0, 1, 0, 4'd0, 8'h00);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL seq_load: got %h want %h", obs, e); end
        for (int r = 1; r <= 10; r++) begin
            tick();
            e = pack(0, 1, (r == 10), 1, 0, 4'(r), exp_rcon(r));
            checks++;
            if (obs !== e) begin errors++; $display("FAIL seq_round%0d: got %h want %h", r, obs, e); end
        end
        tick();
        e = pack(0, 0, 0, 0, 1, 4'd10, 8'h00);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL seq_done: got %h want %h", obs, e); end
    endtask

    task automatic test_hold();
        logic [16:0] e;
        e = pack(0, 0, 0, 0, 1, 4'd10, 8'h00);
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            tick();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL hold_frozen%0d: got %h want %h", i, obs, e); end
        end
        start = 1'b0;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL hold_ack_idle: got %h want %h", obs, IDLE_V); end
        tick();
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL hold_stay_idle: got %h want %h", obs, IDLE_V); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        start = 1'b1;
        for (int blk = 0; blk < 2; blk++) begin
            if (blk == 1) begin
                out_ack = 1'b1;
                tick();
                out_ack = 1'b0;
            end else begin
                tick();
            end
            e = pack(1, 0, 0, 1, 0, 4'd0, 8'h00);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b_load%0d: got %h want %h", blk, obs, e); end
            for (int r = 1; r <= 10; r++) begin
                tick();
                e = pack(0, 1, (r == 10), 1, 0, 4'(r), exp_rcon(r));
                checks++;
                if (obs !== e) begin errors++; $display("FAIL b2b_blk%0d_round%0d: got %h want %h", blk, r, obs, e); end
            end
            tick();
            e = pack(0, 0, 0, 0, 1, 4'd10, 8'h00);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL b2b_done%0d: got %h want %h", blk, obs, e); end
        end
        start = 1'b0;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL b2b_idle: got %h want %h", obs, IDLE_V); end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 5; r++) tick();
        e = pack(0, 1, 0, 1, 0, 4'd5, 8'h10);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rmid_round5: got %h want %h", obs, e); end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL rmid_async_clear: got %h want %h", obs, IDLE_V); end
        tick();
        #2 rstb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== IDLE_V) begin errors++; $display("FAIL rmid_quiet%0d: got %h want %h", i, obs, IDLE_V); end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        e = pack(1, 0, 0, 1, 0, 4'd0, 8'h00);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rmid_restart_load: got %h want %h", obs, e); end
        for (int i = 0; i < 11; i++) tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL rmid_final_idle: got %h want %h", obs, IDLE_V); end
    endtask

    task automatic test_abort();
        logic [16:0] e;
        int done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 1; r <= 7; r++) tick();
        e = pack(0, 1, 0, 1, 0, 4'd7, 8'h40);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_round7: got %h want %h", obs, e); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
`ifdef AES_ABORT_EN
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL abort_idle: got %h want %h", obs, IDLE_V); end
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done cycles want 0", done_seen); end
`else
        done_seen = 0;
        e = pack(0, 1, 0, 1, 0, 4'd8, 8'h80);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_ignored_round8: got %h want %h", obs, e); end
        tick();
        tick();
        e = pack(0, 1, 1, 1, 0, 4'd10, 8'h36);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_ignored_round10: got %h want %h", obs, e); end
        tick();
        e = pack(0, 0, 0, 0, 1, 4'd10, 8'h00);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_ignored_done: got %h want %h", obs, e); end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checks++;
        if (obs !== IDLE_V) begin errors++; $display("FAIL abort_ignored_idle: got %h want %h", obs, IDLE_V); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
